// File: rtl/dds_channel_scheduler_if.sv
// Config, LUT and sample bundle for the shared-LUT DDS scheduler.
// master: requester/LUT side, slave: scheduler side.
interface dds_channel_scheduler_if #(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 32
);
  localparam int CH_W = $clog2(NUM_CH);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [PHASE_W-1:0] cfg_ftw;
  logic [PHASE_W-1:0] cfg_offset;
  logic               cfg_clr;
  logic [10:0]        lut_addr;
  logic [16:0]        lut_value;
  logic               sample_valid;
  logic [CH_W-1:0]    sample_ch;
  logic [16:0]        sample_data;
  logic               frame_done;

  modport master (
    output cfg_valid, cfg_ch, cfg_ftw,
    output cfg_offset, cfg_clr, lut_value,
    input  cfg_ready, lut_addr, sample_valid,
    input  sample_ch, sample_data, frame_done
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_ftw,
    input  cfg_offset, cfg_clr, lut_value,
    output cfg_ready, lut_addr, sample_valid,
    output sample_ch, sample_data, frame_done
  );
endinterface

// File: rtl/dds_channel_scheduler.sv
// Round-robin DDS channel scheduler sharing one pipelined sine LUT.
// Each issue tags its channel; the tag re-joins the LUT output.
module dds_channel_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int PHASE_W     = 32,
  parameter int LUT_LATENCY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic busy,
  dds_channel_scheduler_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(LUT_LATENCY + 1);
  localparam logic [CH_W-1:0] LAST_CH =
    CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(LUT_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    slot_q, slot_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic               issue;
  logic               last_slot;
  logic               cfg_fire;
  logic [PHASE_W-1:0] phase;

  logic [PHASE_W-1:0] acc_q [NUM_CH];
  logic [PHASE_W-1:0] ftw_q [NUM_CH];
  logic [PHASE_W-1:0] off_q [NUM_CH];

  logic [10:0]        lut_addr_q;
  logic [LUT_LATENCY:0] tag_vld_q;
  logic [CH_W-1:0]    tag_ch_q [LUT_LATENCY+1];
  logic               smp_vld_q;
  logic [CH_W-1:0]    smp_ch_q;
  logic [16:0]        smp_data_q;

  assign last_slot = (state_q == RUN) &&
                     (slot_q == LAST_CH);
  assign bus.cfg_ready = (state_q != RUN) ||
                         last_slot;
  assign cfg_fire = bus.cfg_valid && bus.cfg_ready;
  assign phase = acc_q[slot_q] + off_q[slot_q];

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    dcnt_d  = dcnt_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          slot_d  = '0;
        end
      end
      RUN: begin
        issue  = 1'b1;
        slot_d = slot_q + CH_W'(1);
        if (last_slot && !enable) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        if (dcnt_q == LAST_CNT) state_d = IDLE;
        else dcnt_d = dcnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      dcnt_q     <= '0;
      lut_addr_q <= '0;
      tag_vld_q  <= '0;
      smp_vld_q  <= 1'b0;
      smp_ch_q   <= '0;
      smp_data_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        ftw_q[i] <= '0;
        off_q[i] <= '0;
      end
      for (int i = 0; i <= LUT_LATENCY; i++)
        tag_ch_q[i] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      dcnt_q  <= dcnt_d;
      if (issue) begin
        acc_q[slot_q] <= acc_q[slot_q] +
                         ftw_q[slot_q];
        lut_addr_q <= phase[PHASE_W-1 -: 11];
      end
      // Later write wins: clear overrides the accumulate
      if (cfg_fire) begin
        ftw_q[bus.cfg_ch] <= bus.cfg_ftw;
        off_q[bus.cfg_ch] <= bus.cfg_offset;
        if (bus.cfg_clr)
          acc_q[bus.cfg_ch] <= '0;
      end
      tag_vld_q <= {tag_vld_q[LUT_LATENCY-1:0],
                    issue};
      tag_ch_q[0] <= slot_q;
      for (int i = 1; i <= LUT_LATENCY; i++)
        tag_ch_q[i] <= tag_ch_q[i-1];
      smp_vld_q <= tag_vld_q[LUT_LATENCY];
      if (tag_vld_q[LUT_LATENCY]) begin
        smp_data_q <= bus.lut_value;
        smp_ch_q   <= tag_ch_q[LUT_LATENCY];
      end
    end
  end

  assign bus.lut_addr     = lut_addr_q;
  assign bus.sample_valid = smp_vld_q;
  assign bus.sample_ch    = smp_ch_q;
  assign bus.sample_data  = smp_data_q;
  assign bus.frame_done   = smp_vld_q &&
                            (smp_ch_q == LAST_CH);
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Directed bench for dds_channel_scheduler with a 3-stage LUT model.
// Expected addresses per frame are hand-computed tables.
module tb_dds_channel_scheduler;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic busy;

  dds_channel_scheduler_if #(
    .NUM_CH(N), .PHASE_W(W)
  ) bus ();

  dds_channel_scheduler #(
    .NUM_CH(N), .PHASE_W(W), .LUT_LATENCY(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .busy(busy),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] lutf(
    input logic [10:0] a);
    return {a[4:0], a, 1'b1};
  endfunction

  logic [16:0] l1 = '0, l2 = '0, l3 = '0;
  always @(posedge clk) begin
    l1 <= lutf(bus.lut_addr);
    l2 <= l1;
    l3 <= l2;
  end
  assign bus.lut_value = l3;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int cfg_on = 0;
  int cfg_off = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h",
             tag, got, want);
    end
  endtask

  task automatic push4(input int a, input int b,
                       input int c, input int d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  task automatic cfg_write(input int ch,
                           input logic [31:0] ftw,
                           input logic [31:0] off,
                           input bit clr);
    bus.cfg_ch     = 2'(ch);
    bus.cfg_ftw    = ftw;
    bus.cfg_offset = off;
    bus.cfg_clr    = clr;
    bus.cfg_valid  = 1'b1;
    chk("cfg_idle_ready", 32'(bus.cfg_ready), 1);
    step();
    bus.cfg_valid = 1'b0;
    bus.cfg_clr   = 1'b0;
  endtask

  // Starts from IDLE; checks address, sample, busy and
  // ready streams against exp_q for nf frames.
  task automatic run_frames(input int nf,
                            input int drop,
                            input bit reen,
                            input int nxt);
    int last;
    int j;
    last = 4 * nf;
    enable = 1'b1;
    for (int cyc = 1; cyc <= last + 5; cyc++) begin
      step();
      if (cyc == 1 + 4 * (nf - 1) + drop)
        enable = 1'b0;
      if (reen && cyc == last + 2) enable = 1'b1;
      if (cyc == cfg_on) bus.cfg_valid = 1'b1;
      if (cyc == cfg_off) bus.cfg_valid = 1'b0;
      if (cyc >= 2 && cyc <= last + 1)
        chk("addr", 32'(bus.lut_addr),
            32'(exp_q[cyc-2]));
      if (cyc >= 6) begin
        j = cyc - 6;
        chk("sv", 32'(bus.sample_valid), 1);
        chk("sch", 32'(bus.sample_ch), 32'(j % 4));
        chk("sdata", 32'(bus.sample_data),
            32'(lutf(11'(exp_q[j]))));
        chk("fdone", 32'(bus.frame_done),
            32'(j % 4 == 3));
      end else begin
        chk("sv_early", 32'(bus.sample_valid), 0);
      end
      chk("busy", 32'(busy),
          32'((cyc <= last + 3) ||
              (reen && cyc >= last + 5)));
      if (cyc <= last)
        chk("ready_run", 32'(bus.cfg_ready),
            32'((cyc - 1) % 4 == 3));
      else
        chk("ready_idle", 32'(bus.cfg_ready),
            32'(!(reen && cyc == last + 5)));
    end
    step();
    chk("sv_after", 32'(bus.sample_valid), 0);
    if (reen) begin
      chk("restart_addr", 32'(bus.lut_addr),
          32'(nxt));
      enable = 1'b0;
      for (int k = 0; k < 20 && busy; k++) step();
      chk("restart_idle", 32'(busy), 0);
      repeat (6) step();
    end
    exp_q.delete();
    cfg_on  = 0;
    cfg_off = 0;
  endtask

  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_ch     = '0;
    bus.cfg_ftw    = '0;
    bus.cfg_offset = '0;
    bus.cfg_clr    = 1'b0;

    repeat (2) step();
    chk("rst_addr", 32'(bus.lut_addr), 0);
    chk("rst_sv", 32'(bus.sample_valid), 0);
    chk("rst_ready", 32'(bus.cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step();

    // Reset with three tags in flight
    cfg_write(0, 32'h0020_0000, 0, 0);
    enable = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("t1_addr", 32'(bus.lut_addr), 0);
    chk("t1_sv", 32'(bus.sample_valid), 0);
    chk("t1_sch", 32'(bus.sample_ch), 0);
    chk("t1_sdata", 32'(bus.sample_data), 0);
    chk("t1_fd", 32'(bus.frame_done), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_ready", 32'(bus.cfg_ready), 1);
    enable = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) begin
      step();
      chk("t1_quiet", 32'(bus.sample_valid), 0);
    end

    // FTW step on ch0
    cfg_write(0, 32'h0020_0000, 0, 0);
    push4(0, 0, 0, 0);
    push4(1, 0, 0, 0);
    push4(2, 0, 0, 0);
    push4(3, 0, 0, 0);
    run_frames(4, 0, 1'b0, 0);

    // Half-range FTW wrap on ch2
    cfg_write(2, 32'h8000_0000, 0, 0);
    push4(4, 0, 0, 0);
    push4(5, 0, 1024, 0);
    push4(6, 0, 0, 0);
    run_frames(3, 0, 1'b0, 0);

    // Offset wrap on ch2 after clearing its accumulator
    cfg_write(2, 32'h8000_0000, 32'hFFE0_0000, 1);
    push4(7, 0, 2047, 0);
    push4(8, 0, 1023, 0);
    run_frames(2, 0, 1'b0, 0);

    // Mid-frame config on ch1 lands at slot 3
    bus.cfg_ch     = 2'd1;
    bus.cfg_ftw    = 32'h0040_0000;
    bus.cfg_offset = 32'h0;
    bus.cfg_clr    = 1'b0;
    cfg_on  = 2;
    cfg_off = 5;
    push4(9, 0, 2047, 0);
    push4(10, 0, 1023, 0);
    push4(11, 2, 2047, 0);
    run_frames(3, 0, 1'b0, 0);

    // Clear on ch0 with new offset
    bus.cfg_ch     = 2'd0;
    bus.cfg_ftw    = 32'h0020_0000;
    bus.cfg_offset = 32'h0060_0000;
    bus.cfg_clr    = 1'b1;
    cfg_on  = 1;
    cfg_off = 5;
    push4(12, 4, 1023, 0);
    push4(3, 6, 2047, 0);
    run_frames(2, 0, 1'b0, 0);
    bus.cfg_clr = 1'b0;

    // Drop enable at slot 1 of the last frame
    push4(4, 8, 1023, 0);
    push4(5, 10, 2047, 0);
    run_frames(2, 1, 1'b0, 0);

    // Re-enable during drain
    push4(6, 12, 1023, 0);
    run_frames(1, 0, 1'b1, 7);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
